// File: rtl/pc_fetch_stage.sv
// PC register and IF/ID pipeline register for the fetch stage.
// Resolves branches from the zero flag and tracks taken-branch flushes.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  op,
    output logic [15:0] flush_count
);

    logic [31:0] pcReg;
    logic [31:0] pcPlus4;
    logic        branchTaken;
    logic        flushSat;

    assign branchTaken = (branch_eq & zero) | (branch_ne & ~zero);
    assign pcPlus4     = pcReg + 32'd4;
    assign flushSat    = (flush_count == 16'hFFFF);

    assign imem_addr = pcReg;
    assign op        = if_id_instr[31:26];

    // A taken branch wins over stall; the pc4 field is left as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg       <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            flush_count <= 16'd0;
        end else if (branchTaken) begin
            pcReg       <= {branch_target[31:2], 2'b00};
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (!flushSat) begin
                flush_count <= flush_count + 16'd1;
            end
        end else if (!stall) begin
            pcReg       <= pcPlus4;
            if_id_instr <= imem_data;
            if_id_pc4   <= pcPlus4;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed testbench for pc_fetch_stage.
// Inputs change #1 after each rising edge; outputs are checked there too.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_eq;
    logic        branch_ne;
    logic        zero;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op;
    logic [15:0] flush_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_eq    (branch_eq),
        .branch_ne    (branch_ne),
        .zero         (zero),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .op           (op),
        .flush_count  (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setBr(input logic eq, input logic ne, input logic z,
                         input logic [31:0] tgt);
        branch_eq     = eq;
        branch_ne     = ne;
        zero          = z;
        branch_target = tgt;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        imem_data = 32'h2008_0005;
        setBr(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rst_addr", imem_addr, 32'h0040_0000);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_flush", {16'b0, flush_count}, 32'h0);

        // sequential fetch
        reset = 1'b0;
        step();
        chk("seq1_addr", imem_addr, 32'h0040_0004);
        chk("seq1_pc4", if_id_pc4, 32'h0040_0004);
        chk("seq1_instr", if_id_instr, 32'h2008_0005);
        chk("seq1_valid", {31'b0, if_id_valid}, 32'h1);
        chk("seq1_op", {26'b0, op}, 32'h08);
        step();
        chk("seq2_addr", imem_addr, 32'h0040_0008);

        // stall two cycles
        stall = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'h0040_0008);
            chk("stall_instr", if_id_instr, 32'h2008_0005);
            chk("stall_pc4", if_id_pc4, 32'h0040_0008);
            chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        chk("unstall_addr", imem_addr, 32'h0040_000C);
        chk("unstall_instr", if_id_instr, 32'hDEAD_BEEF);
        chk("unstall_op", {26'b0, op}, 32'h37);

        // BEQ taken with concurrent stall
        stall = 1'b1;
        setBr(1'b1, 1'b0, 1'b1, 32'h0040_0040);
        step();
        chk("beq_addr", imem_addr, 32'h0040_0040);
        chk("beq_instr", if_id_instr, 32'h0);
        chk("beq_valid", {31'b0, if_id_valid}, 32'h0);
        chk("beq_flush", {16'b0, flush_count}, 32'h1);
        chk("beq_pc4", if_id_pc4, 32'h0040_000C);
        chk("beq_op", {26'b0, op}, 32'h0);

        // BNE not taken, then taken with unaligned target
        stall = 1'b0;
        setBr(1'b0, 1'b1, 1'b1, 32'h0040_0043);
        step();
        chk("bnent_addr", imem_addr, 32'h0040_0044);
        chk("bnent_flush", {16'b0, flush_count}, 32'h1);
        chk("bnent_valid", {31'b0, if_id_valid}, 32'h1);
        chk("bnent_pc4", if_id_pc4, 32'h0040_0044);
        zero = 1'b0;
        step();
        chk("bne_addr", imem_addr, 32'h0040_0040);
        chk("bne_flush", {16'b0, flush_count}, 32'h2);

        // both branch flags: taken for either zero value
        setBr(1'b1, 1'b1, 1'b0, 32'h0040_0080);
        step();
        chk("both0_addr", imem_addr, 32'h0040_0080);
        setBr(1'b1, 1'b1, 1'b1, 32'h0040_0100);
        step();
        chk("both1_addr", imem_addr, 32'h0040_0100);
        chk("both_flush", {16'b0, flush_count}, 32'h4);

        // BEQ not taken
        setBr(1'b1, 1'b0, 1'b0, 32'h0000_0000);
        step();
        chk("beqnt_addr", imem_addr, 32'h0040_0104);

        // wrap around
        setBr(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step();
        chk("wrapset_addr", imem_addr, 32'hFFFF_FFFC);
        setBr(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", if_id_pc4, 32'h0000_0000);
        chk("wrap_valid", {31'b0, if_id_valid}, 32'h1);

        // reset during branch and stall
        reset = 1'b1;
        stall = 1'b1;
        setBr(1'b1, 1'b0, 1'b1, 32'h0000_1000);
        step();
        chk("rstbr_addr", imem_addr, 32'h0040_0000);
        chk("rstbr_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rstbr_flush", {16'b0, flush_count}, 32'h0);
        chk("rstbr_pc4", if_id_pc4, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        setBr(1'b0, 1'b0, 1'b0, 32'h0);
        imem_data = 32'h2008_0005;
        step();
        chk("rel_valid", {31'b0, if_id_valid}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0040_0004);

        // flush counter saturation
        setBr(1'b1, 1'b0, 1'b1, 32'h0040_0000);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'b0, flush_count}, 32'h0000_FFFE);
        step();
        chk("sat_ffff", {16'b0, flush_count}, 32'h0000_FFFF);
        step();
        chk("sat_hold", {16'b0, flush_count}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the PC value loaded on reset.
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word injected into IF/ID on flush and reset.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port stall, input, 1, hazard hold request from the hazard unit.
REQ-006 The module SHALL have port branch_eq, input, 1, BranchEQ from the decode control unit for the instruction being resolved.
REQ-007 The module SHALL have port branch_ne, input, 1, BranchNE from the decode control unit for the instruction being resolved.
REQ-008 The module SHALL have port zero, input, 1, ALU zero flag for the instruction being resolved.
REQ-009 The module SHALL have port branch_target, input, 32, resolved branch destination address.
REQ-010 The module SHALL have port imem_addr, output, 32, instruction memory address (current PC).
REQ-011 The module SHALL have port imem_data, input, 32, instruction word at imem_addr, combinational same-cycle read.
REQ-012 The module SHALL have port if_id_instr, output, 32, registered instruction for decode.
REQ-013 The module SHALL have port if_id_pc4, output, 32, registered PC+4 of that instruction.
REQ-014 The module SHALL have port if_id_valid, output, 1, high when if_id_instr is a real fetched instruction.
REQ-015 The module SHALL have port op, output, 6, if_id_instr[31:26], driving the control unit OP input.
REQ-016 The module SHALL have port flush_count, output, 16, number of taken-branch flushes since reset.

Function
REQ-017 The module SHALL compute branch_taken = (branch_eq & zero) | (branch_ne & ~zero), combinationally.
REQ-018 The module SHALL drive imem_addr directly from the PC register, with zero added latency.
REQ-019 The module SHALL, on a cycle with branch_taken=1, load PC <= {branch_target[31:2],2'b00}, IF/ID <= {NOP_INSTR, if_id_pc4 unchanged}, if_id_valid <= 0, and flush_count <= flush_count+1.
REQ-020 The module SHALL, on a cycle with branch_taken=0 and stall=1, hold PC, if_id_instr, if_id_pc4, and if_id_valid unchanged.
REQ-021 The module SHALL, on a cycle with branch_taken=0 and stall=0, load PC <= PC+4, if_id_instr <= imem_data, if_id_pc4 <= PC+4, and if_id_valid <= 1.
REQ-022 Priority SHALL be reset > branch_taken > stall > normal advance; a taken branch overrides a concurrent stall.
REQ-023 PC+4 SHALL be modulo 2^32: PC=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-024 branch_eq and branch_ne both high SHALL be legal, evaluated per REQ-017, which makes the branch always taken.
REQ-025 flush_count SHALL saturate at 16'hFFFF and not wrap.
REQ-026 op SHALL always equal if_id_instr[31:26], including while if_id_valid=0 (the NOP decodes as R-type; downstream qualifies with if_id_valid).
REQ-027 The PC SHALL always be word-aligned; bits [1:0] of PC and imem_addr SHALL never be nonzero.

Reset
REQ-028 On a clock edge with reset=1, the module SHALL set PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, and flush_count=0, regardless of stall or branch inputs.
REQ-029 After reset deasserts, the first edge SHALL capture imem_data at RESET_PC, giving if_id_valid=1 one cycle after reset release.
REQ-030 Reset asserted mid-stall or mid-branch SHALL discard the pending operation entirely.

Verification
REQ-031 Sequential fetch: reset then 3 free cycles with imem returning 32'h2008_0005 (addi): imem_addr sequence 0x00400000, 0x00400004, 0x00400008; if_id_pc4=0x00400004 after 1st edge; op=6'h08.
REQ-032 Stall: stall=1 for 2 cycles at PC=0x00400008: PC, if_id_instr, and if_id_valid are unchanged for both cycles; advance to 0x0040000C resumes on the first cycle with stall=0.
REQ-033 BEQ taken with concurrent stall: branch_eq=1, zero=1, stall=1, branch_target=0x00400040: next PC=0x00400040, if_id_instr=0, if_id_valid=0, flush_count=1.
REQ-034 BNE not taken: branch_ne=1, zero=1: PC advances by 4 and flush_count is unchanged; with target 0x00400043 and zero=0 the branch is taken and PC=0x00400040.
REQ-035 Wrap: force PC to 0xFFFFFFFC via branch_target, then one free cycle: PC=0x00000000 and if_id_pc4=0x00000000.
REQ-036 Reset mid-branch: reset=1 together with branch_eq=1, zero=1: PC=0x00400000, if_id_valid=0, and flush_count=0.
